// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, the FSM state type and DDRAM address helpers
// for the HD44780-compatible LCD responder.
package lcd_pkg;

    // Instruction opcodes; the highest set bit of a command byte selects the instruction
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPCTL = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNCSET = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    // DDRAM geometry: two 40-character lines at 0x00 and 0x40
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int         LINE_LEN   = 40;
    localparam logic [6:0] LINE0_LAST = LINE0_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // The blanking sweep walks 0x00..0x67, covering both lines (104 cycles)
    localparam logic [6:0] SWEEP_LAST = LINE1_LAST;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_EXEC
    } state_t;

    // True for addresses that map onto a visible character cell
    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= LINE0_LAST) || ((a >= LINE1_BASE) && (a <= LINE1_LAST));
    endfunction

    // Next address counter value, wrapping line 0 end -> line 1 start and back
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE0_LAST) return LINE1_BASE;
            if (a == LINE1_LAST) return LINE0_BASE;
            return a + 7'd1;
        end
        if (a == LINE1_BASE) return LINE0_LAST;
        if (a == LINE0_BASE) return LINE1_LAST;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 128x8 dual-port display RAM. Port A writes and reads (read-first),
// port B is a read-only side port. Both read outputs are registered.
module lcd_ddram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_we,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    input  logic [6:0] b_addr,
    output logic [7:0] b_rdata
);

    logic [7:0] mem [0:127];

    // Storage: no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Registered reads; a same-cycle write to the read address returns the old byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= 8'h00;
            b_rdata <= 8'h00;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: device side of a 4-bit HD44780 bus. Decodes nibble writes into
// instructions/data, keeps DDRAM, address counter, flags and busy timing, and
// answers busy-flag and data reads. Define LCD_RESP_BUSY_EN to enable busy timing.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_SHORT = 3700,
    parameter int BUSY_LONG  = 152000
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] LCDDATA_I,
    output logic [3:0] LCDDATA_O,
    output logic       LCDDATA_OE,
    input  logic       RS,
    input  logic       RW,
    input  logic       EN,
    input  logic [6:0] DD_ADDR,
    output logic [7:0] DD_DATA,
    output logic       BUSY,
    output logic [6:0] AC,
    output logic       DISP_ON,
    output logic       MODE4,
    output logic       ERR
);

    logic [6:0] sync1_reg, sync2_reg;
    logic       en_d_reg;
    logic       en_s, rw_s, rs_s, en_rise, en_fall;
    logic [3:0] dat_s;

    state_t     state_reg, state_next;
    logic       rd_reg, rd_next, rd_rs_reg, rd_rs_next;
    logic       cap_rs_reg, cap_rs_next;
    logic [3:0] cap_nib_reg, cap_nib_next;
    logic       phase_reg, phase_next;            // 0 = HIGH nibble expected
    logic [3:0] hi_nib_reg, hi_nib_next;
    logic       hi_rs_reg, hi_rs_next;
    logic [6:0] ac_reg, ac_next;
    logic       id_reg, id_next;
    logic       disp_reg, disp_next, cur_reg, cur_next, blink_reg, blink_next;
    logic       mode4_reg, mode4_next;
    logic       err_reg, err_next;
    logic       oe_reg, oe_next;
    logic [3:0] dout_reg, dout_next;
    logic       sweep_reg, sweep_next;
    logic [6:0] sweep_cnt_reg;
    logic       busy_now, busy_load, busy_long, clear_req, wr_en, complete, low_phase;
    logic [7:0] byte_val, wr_data, ram_rdata;

    // Cursor and blink have no visible effect in this model; kept for completeness
    logic unused_ctl;
    assign unused_ctl = cur_reg ^ blink_reg;

    // Two-flop synchronizers on all bus inputs, plus EN edge history
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            en_d_reg  <= 1'b0;
        end else begin
            sync1_reg <= {EN, RW, RS, LCDDATA_I};
            sync2_reg <= sync1_reg;
            en_d_reg  <= sync2_reg[6];
        end
    end

    assign en_s    = sync2_reg[6];
    assign rw_s    = sync2_reg[5];
    assign rs_s    = sync2_reg[4];
    assign dat_s   = sync2_reg[3:0];
    assign en_rise = en_s & ~en_d_reg;
    assign en_fall = ~en_s & en_d_reg;
    assign low_phase = mode4_reg & phase_reg;

    // Next-state, byte assembly and instruction decode
    always_comb begin
        state_next   = state_reg;
        rd_next      = rd_reg;
        rd_rs_next   = rd_rs_reg;
        cap_rs_next  = cap_rs_reg;
        cap_nib_next = cap_nib_reg;
        phase_next   = phase_reg;
        hi_nib_next  = hi_nib_reg;
        hi_rs_next   = hi_rs_reg;
        ac_next      = ac_reg;
        id_next      = id_reg;
        disp_next    = disp_reg;
        cur_next     = cur_reg;
        blink_next   = blink_reg;
        mode4_next   = mode4_reg;
        oe_next      = oe_reg;
        dout_next    = dout_reg;
        err_next     = 1'b0;
        wr_en        = 1'b0;
        clear_req    = 1'b0;
        busy_load    = 1'b0;
        busy_long    = 1'b0;
        complete     = 1'b0;
        byte_val     = {hi_nib_reg, cap_nib_reg};
        wr_data      = byte_val;
        case (state_reg)
            ST_IDLE: begin
                if (en_rise) begin
                    state_next = ST_STROBE;
                    rd_next    = rw_s;
                    rd_rs_next = rs_s;
                    if (rw_s) begin
                        oe_next = 1'b1;
                        if (rs_s) dout_next = low_phase ? ram_rdata[3:0] : ram_rdata[7:4];
                        else      dout_next = low_phase ? ac_reg[3:0] : {busy_now, ac_reg[6:4]};
                    end
                end
            end
            ST_STROBE: begin
                if (en_fall) begin
                    if (rd_reg) begin
                        // Reads finish here; data reads step AC after the last nibble
                        oe_next    = 1'b0;
                        state_next = ST_IDLE;
                        if (mode4_reg) phase_next = ~phase_reg;
                        if (rd_rs_reg && (!mode4_reg || phase_reg)) ac_next = ac_step(ac_reg, id_reg);
                    end else begin
                        cap_rs_next  = rs_s;
                        cap_nib_next = dat_s;
                        state_next   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_next = ST_IDLE;
                if (!mode4_reg) begin
                    byte_val = {cap_nib_reg, 4'h0};
                    complete = 1'b1;
                end else if (!phase_reg) begin
                    hi_nib_next = cap_nib_reg;
                    hi_rs_next  = cap_rs_reg;
                    phase_next  = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    if (cap_rs_reg != hi_rs_reg) err_next = 1'b1;
                    else                         complete = 1'b1;
                end
                wr_data = byte_val;
                if (complete) begin
                    if (busy_now) begin
                        err_next = 1'b1;
                    end else begin
                        busy_load = 1'b1;
                        if (cap_rs_reg) begin
                            wr_en   = 1'b1;
                            ac_next = ac_step(ac_reg, id_reg);
                        end else if (|(byte_val & OP_DDRAM)) begin
                            if (addr_valid(byte_val[6:0])) ac_next  = byte_val[6:0];
                            else                           err_next = 1'b1;
                        end else if (|(byte_val & OP_CGRAM)) begin
                            ac_next = ac_reg;
                        end else if (|(byte_val & OP_FUNCSET)) begin
                            mode4_next = ~byte_val[4];
                            phase_next = 1'b0;
                        end else if (|(byte_val & OP_SHIFT)) begin
                            if (!byte_val[3]) ac_next = ac_step(ac_reg, byte_val[2]);
                        end else if (|(byte_val & OP_DISPCTL)) begin
                            disp_next  = byte_val[2];
                            cur_next   = byte_val[1];
                            blink_next = byte_val[0];
                        end else if (|(byte_val & OP_ENTRY)) begin
                            id_next = byte_val[1];
                        end else if (|(byte_val & OP_HOME)) begin
                            ac_next   = 7'h00;
                            busy_long = 1'b1;
                        end else if (|(byte_val & OP_CLEAR)) begin
                            ac_next   = 7'h00;
                            id_next   = 1'b1;
                            clear_req = 1'b1;
                            busy_long = 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state and control/datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg   <= ST_IDLE;
            rd_reg      <= 1'b0;
            rd_rs_reg   <= 1'b0;
            cap_rs_reg  <= 1'b0;
            cap_nib_reg <= 4'h0;
            phase_reg   <= 1'b0;
            hi_nib_reg  <= 4'h0;
            hi_rs_reg   <= 1'b0;
            ac_reg      <= 7'h00;
            id_reg      <= 1'b1;
            disp_reg    <= 1'b0;
            cur_reg     <= 1'b0;
            blink_reg   <= 1'b0;
            mode4_reg   <= 1'b0;
            err_reg     <= 1'b0;
            oe_reg      <= 1'b0;
            dout_reg    <= 4'h0;
        end else begin
            state_reg   <= state_next;
            rd_reg      <= rd_next;
            rd_rs_reg   <= rd_rs_next;
            cap_rs_reg  <= cap_rs_next;
            cap_nib_reg <= cap_nib_next;
            phase_reg   <= phase_next;
            hi_nib_reg  <= hi_nib_next;
            hi_rs_reg   <= hi_rs_next;
            ac_reg      <= ac_next;
            id_reg      <= id_next;
            disp_reg    <= disp_next;
            cur_reg     <= cur_next;
            blink_reg   <= blink_next;
            mode4_reg   <= mode4_next;
            err_reg     <= err_next;
            oe_reg      <= oe_next;
            dout_reg    <= dout_next;
        end
    end

    assign sweep_next = clear_req | (sweep_reg & (sweep_cnt_reg != SWEEP_LAST));

    // Blanking sweep after reset and on clear; owns the RAM write port while active
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sweep_reg     <= 1'b1;
            sweep_cnt_reg <= 7'h00;
        end else begin
            sweep_reg     <= sweep_next;
            sweep_cnt_reg <= (clear_req || !sweep_reg) ? 7'h00 : sweep_cnt_reg + 7'd1;
        end
    end

`ifdef LCD_RESP_BUSY_EN
    localparam int BW = $clog2(BUSY_LONG + 1);
    logic [BW-1:0] busy_cnt_reg, busy_cnt_next;
    logic          busy_reg;

    // Busy countdown: loaded at EXEC, BUSY high for exactly the loaded count
    always_comb begin
        busy_cnt_next = busy_cnt_reg;
        if (busy_load)                 busy_cnt_next = busy_long ? BW'(BUSY_LONG) : BW'(BUSY_SHORT);
        else if (busy_cnt_reg != '0)   busy_cnt_next = busy_cnt_reg - 1'b1;
    end

    // Busy counter and registered flag (also high during the blanking sweep)
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_cnt_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            busy_cnt_reg <= busy_cnt_next;
            busy_reg     <= sweep_next | (busy_cnt_next != '0);
        end
    end

    assign busy_now = busy_reg;
`else
    // Busy timing removed: the flag never rises and nothing is discarded
    logic unused_busy;
    assign unused_busy = busy_load ^ busy_long ^ (^BUSY_SHORT) ^ (^BUSY_LONG);
    assign busy_now    = 1'b0;
`endif

    lcd_ddram u_ddram (
        .clk     (CLK),
        .rst_n   (nRST),
        .a_we    (sweep_reg | wr_en),
        .a_addr  (sweep_reg ? sweep_cnt_reg : ac_reg),
        .a_wdata (sweep_reg ? BLANK_CHAR : wr_data),
        .a_rdata (ram_rdata),
        .b_addr  (DD_ADDR),
        .b_rdata (DD_DATA)
    );

    assign LCDDATA_O  = dout_reg;
    assign LCDDATA_OE = oe_reg;
    assign BUSY       = busy_now;
    assign AC         = ac_reg;
    assign DISP_ON    = disp_reg;
    assign MODE4      = mode4_reg;
    assign ERR        = err_reg;

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: directed bench for lcd_responder driving the 4-bit bus like
// the sysele driver. Busy-dependent expectations follow LCD_RESP_BUSY_EN.
module tb_lcd_responder;

    localparam int BS = 20;
    localparam int BL = 200;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] lcd_i = 4'h0;
    logic [3:0] lcd_o;
    logic       lcd_oe;
    logic       rs = 1'b0, rw = 1'b0, en = 1'b0;
    logic [6:0] dd_addr = 7'h00;
    logic [7:0] dd_data;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, mode4, err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int busy_run = 0;
    int last_run = 0;

    lcd_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
        .CLK(clk), .nRST(nrst), .LCDDATA_I(lcd_i), .LCDDATA_O(lcd_o),
        .LCDDATA_OE(lcd_oe), .RS(rs), .RW(rw), .EN(en), .DD_ADDR(dd_addr),
        .DD_DATA(dd_data), .BUSY(busy), .AC(ac), .DISP_ON(disp_on),
        .MODE4(mode4), .ERR(err)
    );

    always #5 clk = ~clk;

    // Count ERR pulses and measure the length of each BUSY-high run
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic nib_write(input logic r, input logic [3:0] n);
        @(negedge clk); rs = r; rw = 1'b0; lcd_i = n;
        @(negedge clk); en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_val("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic byte_write(input logic r, input logic [7:0] b);
        nib_write(r, b[7:4]);
        nib_write(r, b[3:0]);
        $display("wr rs=%0d byte=0x%02h ac=0x%02h busy=%0d", r, b, ac, busy);
    endtask

    task automatic cmd8(input logic [3:0] n);
        nib_write(1'b0, n);
        $display("wr8 nib=0x%0h mode4=%0d", n, mode4);
        wait_idle();
    endtask

    task automatic cmd(input logic [7:0] b);
        byte_write(1'b0, b);
        wait_idle();
    endtask

    task automatic dat(input logic [7:0] b);
        byte_write(1'b1, b);
        wait_idle();
    endtask

    task automatic nib_read(input logic r, output logic [3:0] n);
        logic oe;
        @(negedge clk); rs = r; rw = 1'b1;
        @(negedge clk); en = 1'b1;
        repeat (5) @(negedge clk);
        n  = lcd_o;
        oe = lcd_oe;
        en = 1'b0;
        repeat (5) @(negedge clk);
        rw = 1'b0;
        check_val("read_oe", {31'd0, oe}, 32'd1);
        $display("rd rs=%0d nib=0x%0h", r, n);
    endtask

    task automatic dd_read(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk); dd_addr = a;
        @(negedge clk); d = dd_data;
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] nh, nl;
        int blanks;
        int e0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ac", {25'd0, ac}, 32'h0);
        check_val("rst_mode4", {31'd0, mode4}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_oe", {31'd0, lcd_oe}, 32'd0);
        check_val("rst_dd", {24'd0, dd_data}, 32'h0);
        nrst = 1'b1;
        repeat (120) @(negedge clk);
        wait_idle();
        blanks = 0;
        for (int a = 0; a < 128; a++) begin
            if ((a < 8'h28) || (a >= 8'h40 && a < 8'h68)) begin
                dd_read(7'(a), d);
                if (d == 8'h20) blanks++;
            end
        end
        check_val("init_blank", blanks, 80);
        check_val("init_ac", {25'd0, ac}, 32'h0);

        // 8-bit wake-up sequence, then 4-bit function set
        e0 = err_cnt;
        cmd8(4'h3); cmd8(4'h3); cmd8(4'h3);
        check_val("mode4_still8", {31'd0, mode4}, 32'd0);
        cmd8(4'h2);
        check_val("mode4_set", {31'd0, mode4}, 32'd1);
        cmd(8'h28);
        check_val("mode4_kept", {31'd0, mode4}, 32'd1);
        check_val("init_noerr", err_cnt - e0, 0);

        // Display on, increment mode, text "HI"
        cmd(8'h0C);
        cmd(8'h06);
        dat(8'h48);
        dat(8'h49);
        check_val("disp_on", {31'd0, disp_on}, 32'd1);
        dd_read(7'h00, d); check_val("dd0_H", {24'd0, d}, 32'h48);
        dd_read(7'h01, d); check_val("dd1_I", {24'd0, d}, 32'h49);
        check_val("ac_after_hi", {25'd0, ac}, 32'h2);

        // Data read back at address 0
        cmd(8'h80);
        nib_read(1'b1, nh);
        nib_read(1'b1, nl);
        check_val("data_read", {24'd0, nh, nl}, 32'h48);
        check_val("ac_after_read", {25'd0, ac}, 32'h1);
        check_val("oe_release", {31'd0, lcd_oe}, 32'd0);

        // Line wrap 0x27 -> 0x40, then an invalid set-address
        cmd(8'hA7);
        check_val("ac_27", {25'd0, ac}, 32'h27);
        dat(8'h41);
        dat(8'h42);
        dd_read(7'h27, d); check_val("dd27", {24'd0, d}, 32'h41);
        dd_read(7'h40, d); check_val("dd40", {24'd0, d}, 32'h42);
        check_val("ac_41", {25'd0, ac}, 32'h41);
        e0 = err_cnt;
        cmd(8'hB0);
        check_val("badaddr_err", err_cnt - e0, 1);
        check_val("badaddr_ac", {25'd0, ac}, 32'h41);

        // Decrement mode wraps 0x40 -> 0x27
        cmd(8'h04);
        cmd(8'hC0);
        dat(8'h43);
        dd_read(7'h40, d); check_val("dd40_dec", {24'd0, d}, 32'h43);
        check_val("ac_dec_wrap", {25'd0, ac}, 32'h27);
        cmd(8'h06);

        // Clear, busy-flag reads and a write issued while busy
        e0 = err_cnt;
        byte_write(1'b0, 8'h01);
`ifdef LCD_RESP_BUSY_EN
        check_val("clear_busy", {31'd0, busy}, 32'd1);
        nib_read(1'b0, nh);
        nib_read(1'b0, nl);
        check_val("bf_busy", {24'd0, nh, nl}, 32'h80);
        byte_write(1'b1, 8'h5A);
        check_val("busy_discard_err", err_cnt - e0, 1);
        wait_idle();
        check_val("clear_busy_len", last_run, BL);
`else
        check_val("clear_nobusy", {31'd0, busy}, 32'd0);
        repeat (120) @(negedge clk);
        check_val("clear_noerr", err_cnt - e0, 0);
`endif
        nib_read(1'b0, nh);
        nib_read(1'b0, nl);
        check_val("bf_idle", {24'd0, nh, nl}, 32'h00);
        dd_read(7'h00, d); check_val("dd0_cleared", {24'd0, d}, 32'h20);
        dd_read(7'h40, d); check_val("dd40_cleared", {24'd0, d}, 32'h20);
        check_val("clear_ac", {25'd0, ac}, 32'h0);

        // Reset between the two nibbles of a byte
        nib_write(1'b0, 4'hC);
        @(negedge clk); nrst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst_mode4", {31'd0, mode4}, 32'd0);
        check_val("midrst_disp", {31'd0, disp_on}, 32'd0);
        nrst = 1'b1;
        repeat (120) @(negedge clk);
        wait_idle();
        cmd8(4'hC);
        check_val("midrst_8bit_ac", {25'd0, ac}, 32'h40);
        check_val("midrst_mode4_after", {31'd0, mode4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable HD44780-compatible LCD responder: the device end of the 4-bit LCD bus (LCDDATA/RS/RW/EN) that the `sysele` LCD driver initiates. It decodes nibble writes into instructions and data, maintains DDRAM, address counter, busy timing and display flags, and answers busy-flag and data reads. It sits in simulation benches, and optionally on-chip for loopback, in place of the physical panel. Its DDRAM is exposed on a side read port so benches can check displayed text directly.

## Interface
- `BUSY_SHORT`, default 3700: busy cycles for ordinary instructions and data writes (37 µs at 100 MHz).
- `BUSY_LONG`, default 152000: busy cycles for clear/home (1.52 ms at 100 MHz).
- `CLK`, in, 1: system clock, 100 MHz; single clock domain.
- `nRST`, in, 1: reset. Asynchronous, active-low.
- `LCDDATA_I`, in, 4: DB[7:4] from the bus.
- `LCDDATA_O`, out, 4: read data to the bus.
- `LCDDATA_OE`, out, 1: drive enable. The top-level tristate is built from `LCDDATA_O`/`LCDDATA_OE`.
- `RS`, `RW`, `EN`, in, 1 each: bus control from the driver.
- `DD_ADDR`, in, 7: side read address into DDRAM.
- `DD_DATA`, out, 8: DDRAM byte at `DD_ADDR`, registered, 1-cycle latency.
- `BUSY`, out, 1: internal busy flag.
- `AC`, out, 7: address counter.
- `DISP_ON`, out, 1: display on/off flag (D bit).
- `MODE4`, out, 1: 1 once 4-bit interface mode is active.
- `ERR`, out, 1: one-cycle pulse on any protocol error.

## Operation
- `RS`, `RW`, `EN` and `LCDDATA_I` pass through 2-flop synchronizers.
- An edge detector on synchronized `EN` produces `en_rise` and `en_fall`.
- Writes (`RW=0`) are captured on `en_fall` using `RS` and data sampled at that edge.
- **Interface mode**
  - After reset the device is in 8-bit mode (`MODE4=0`). Each write is one full instruction, `{nibble, 4'h0}`.
  - A function set with DL=0 (nibble `0x2`) sets `MODE4=1` and resets the nibble phase to HIGH.
  - In 4-bit mode, the HIGH nibble is latched first, then the LOW nibble completes the byte.
  - An `RS` mismatch between the two nibbles pulses `ERR` and drops the byte.
- **Instruction decode** (highest set bit wins):
  - `0x01` clear: DDRAM filled with `0x20`, AC=0, increment mode. Busy `BUSY_LONG`.
  - `0x02`/`0x03` home: AC=0. Busy `BUSY_LONG`.
  - `0x04`–`0x07` entry mode: store I/D (S ignored).
  - `0x08`–`0x0F` display control: store D, C, B.
  - `0x10`–`0x1F` shift: AC ±1 when S/C=0.
  - `0x20`–`0x3F` function set: DL as above.
  - `0x40`–`0x7F` CGRAM address: accepted, ignored.
  - `0x80`–`0xFF` set DDRAM address: AC=`byte[6:0]`.
- **Data write** (`RS=1`): DDRAM[AC] ← byte, then AC steps by I/D.
- **DDRAM map**: valid addresses `0x00`–`0x27` and `0x40`–`0x67`.
  - Increment wraps `0x27`→`0x40` and `0x67`→`0x00`; decrement mirrors this.
  - A set-address to an invalid value pulses `ERR` and leaves AC unchanged.
- **Busy**: every completed byte except reads loads the busy counter. `BUSY`=1 until the counter reaches 0.
  - A write completing while `BUSY` is high is discarded and pulses `ERR`; nibble-phase tracking still advances.
- **Reads** (`RW=1`): `LCDDATA_OE` rises on `en_rise` and falls on `en_fall`.
  - `RS=0`: HIGH nibble = `{BUSY, AC[6:4]}`, LOW nibble = `AC[3:0]`.
  - `RS=1`: nibbles of DDRAM[AC]; AC steps after the LOW nibble.
  - In 8-bit mode only the HIGH nibble is returned.
- **FSM states**: IDLE → (`en_rise`) STROBE → (`en_fall`) EXEC (1 cycle: decode/update) → IDLE. A read returns to IDLE directly from STROBE.
- **Reset** (any time, including mid-byte or mid-busy):
  - Outputs: `LCDDATA_O=0`, `LCDDATA_OE=0`, `BUSY=0`, `AC=0`, `DISP_ON=0`, `MODE4=0`, `ERR=0`, `DD_DATA=0`.
  - State: I/D=1 (increment), nibble phase HIGH, DDRAM filled with `0x20` by a 104-cycle init sweep. `BUSY`=1 during the sweep.

## Timing
- Pin-to-`en_fall` latency: 3 cycles. Instruction effect (AC, DDRAM, `BUSY` rise) is visible 1 cycle after EXEC, i.e. 5 cycles after the EN pin falls.
- `LCDDATA_OE`/`LCDDATA_O` valid 3 cycles after the EN pin rises. The driver holds EN high ≥ 5 cycles for reads.
- `BUSY` stays high for exactly `BUSY_SHORT`/`BUSY_LONG` cycles after EXEC.
- DDRAM: dual-port, write port internal, read port `DD_ADDR`→`DD_DATA`. A same-cycle write/read collision returns the old data.

## Configuration
- `LCD_RESP_BUSY_EN`
  - Defined: busy counter active as above.
  - Undefined: `BUSY` tied 0, counter removed, no busy-discard errors. Used for fast benches.

## Structure
- Package `lcd_pkg`: instruction opcode constants, DDRAM line bases (`0x00`, `0x40`), line length 40, blank char `0x20`, FSM state enum.
- Sub-module `lcd_ddram`: 128×8 dual-port RAM, 80 entries used.
- All other logic in `lcd_responder`.

## Test plan
- Reset, then wait for `BUSY`=0 → all `DD_DATA`=`0x20`, `AC=0`, `MODE4=0`.
- Nibbles `3`,`3`,`3`,`2` in 8-bit mode, then byte `0x28` → `MODE4=1`, no `ERR`.
- Bytes `0x0C`, `0x06`, then data `"HI"` → `DISP_ON=1`, DDRAM[0]=`0x48`, DDRAM[1]=`0x49`, `AC=2`.
- Set address `0xA7`, write 2 data bytes → DDRAM[`0x27`] and DDRAM[`0x40`] written, `AC=0x41`. Set address `0xB0` → `ERR` pulse, AC unchanged.
- Write immediately after `0x01` → `BUSY`=1 for 152000 cycles. Busy-flag read returns `0x8`, then `0x0`. The early write is discarded with `ERR`.
- Assert `nRST` between the two nibbles of a byte → phase resets to HIGH, `MODE4=0`, next nibble treated as an 8-bit instruction.
